sdram_slot_arbiter: RTL

Shares the single SDRAM user port between the game loader's byte stream and the running NES core. Runs on the NES system clock and owns the 4-phase slot counter; `run_nes` is the clock enable derived from it. While a ROM is loading, it buffers loader bytes in a small FIFO and issues one SDRAM write per 4-cycle slot. Once loading completes and the FIFO has drained, it hands the port to the NES and releases NES reset.

---
 rtl/sdram_slot_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sdram_slot_arbiter.sv
// sdram_slot_arbiter: shares the SDRAM user port between the ROM loader byte
// stream and the NES core. Owns the 4-phase slot counter. While loading,
// buffers loader bytes in a small FIFO and issues one write per slot. Hands
// the port to the NES once loading is done and the FIFO is drained.
module sdram_slot_arbiter #(
    parameter int ADDR_W     = 22,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            load_done,
    input  logic                            ld_valid,
    input  logic [ADDR_W-1:0]               ld_addr,
    input  logic [7:0]                      ld_data,
    output logic                            ld_ready,
    output logic                            ld_overflow,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    input  logic [ADDR_W-1:0]               nes_addr,
    input  logic                            nes_read_cpu,
    input  logic                            nes_read_ppu,
    input  logic                            nes_write,
    input  logic [7:0]                      nes_dout,
    output logic [1:0]                      phase,
    output logic                            run_nes,
    output logic                            nes_reset,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic                            mem_we,
    output logic [7:0]                      mem_din,
    output logic                            mem_oe_a,
    output logic                            mem_oe_b
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {LOAD, DRAIN, RUN} state_t;

    state_t              state;
    logic [1:0]          phase_r;
    logic [LVL_W-1:0]    count;
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [ADDR_W-1:0]   fifo_addr [FIFO_DEPTH];
    logic [7:0]          fifo_data [FIFO_DEPTH];
    logic                mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [7:0]          mem_din_r;

    logic slot, full, empty, push, pop;

    assign slot  = (phase_r == 2'd3);
    assign full  = (count == LVL_W'(FIFO_DEPTH));
    assign empty = (count == '0);
    // A full FIFO never accepts, even when a pop lands on the same edge.
    assign push  = ld_valid && !full;
    assign pop   = slot && (state != RUN) && !empty;

    // Free-running slot phase counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) phase_r <= 2'd0;
        else          phase_r <= phase_r + 2'd1;
    end

    // Loader FIFO: storage, pointers, occupancy and sticky overflow.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            ld_overflow <= 1'b0;
        end else begin
            if (push) begin
                fifo_addr[wr_ptr] <= ld_addr;
                fifo_data[wr_ptr] <= ld_data;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + LVL_W'(push) - LVL_W'(pop);
            // A fresh drop wins over the reload clear on the same edge.
            if (ld_valid && full)
                ld_overflow <= 1'b1;
            else if (state == RUN && slot && !load_done)
                ld_overflow <= 1'b0;
        end
    end

    // Write registers: sampled once per slot and held for the whole window.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_we_r   <= 1'b0;
            mem_addr_r <= '0;
            mem_din_r  <= '0;
        end else if (slot && state != RUN) begin
            mem_we_r <= !empty;
            if (!empty) begin
                mem_addr_r <= fifo_addr[rd_ptr];
                mem_din_r  <= fifo_data[rd_ptr];
            end
        end
    end

    // Port ownership FSM; RUN is entered and left only on slot edges so
    // nes_reset only ever moves on a slot edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= LOAD;
            nes_reset <= 1'b1;
        end else begin
            case (state)
                LOAD: if (load_done) state <= DRAIN;
                DRAIN: begin
                    // Last write window closes on this edge; hand over.
                    if (slot && empty && !push) begin
                        state     <= RUN;
                        nes_reset <= 1'b0;
                    end
                end
                RUN: begin
                    if (slot && !load_done) begin
                        state     <= LOAD;
                        nes_reset <= 1'b1;
                    end
                end
                default: begin
                    state     <= LOAD;
                    nes_reset <= 1'b1;
                end
            endcase
        end
    end

    assign phase      = phase_r;
    assign run_nes    = slot;
    assign ld_ready   = !full;
    assign fifo_level = count;

    // In RUN the NES drives the controller directly.
    assign mem_we   = (state == RUN) ? nes_write : mem_we_r;
    assign mem_addr = (state == RUN) ? nes_addr  : mem_addr_r;
    assign mem_din  = (state == RUN) ? nes_dout  : mem_din_r;
    assign mem_oe_a = (state == RUN) && nes_read_cpu;
    assign mem_oe_b = (state == RUN) && nes_read_ppu;

endmodule
